// File: rtl/atm_bank_responder.sv
// Bank-side authorizer: PIN check / withdrawal against a small account table.
// Response valid LATENCY cycles after accept; held stable until rsp_ready, one request in flight at a time.
module atm_bank_responder #(
   parameter int                 NUM_ACCTS    = 4,
   parameter int                 ACCT_W       = 2,
   parameter int                 PIN_W        = 16,
   parameter int                 AMT_W        = 16,
   parameter logic [PIN_W-1:0]   DEFAULT_PIN  = 16'h1234,
   parameter int                 INIT_BALANCE = 1000,
   parameter int                 MAX_TRIES    = 3,
   parameter int                 LATENCY      = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_op,
   input  logic [ACCT_W-1:0] req_acct,
   input  logic [PIN_W-1:0]  req_pin,
   input  logic [AMT_W-1:0]  req_amount,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_pin_correct,
   output logic              rsp_balance_ok,
   output logic              rsp_locked,
   output logic [AMT_W-1:0]  rsp_balance
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_LOOKUP  = 2'd1;
   localparam logic [1:0] S_RESPOND = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic              op_q, op_d;
   logic [ACCT_W-1:0] acct_q, acct_d;
   logic [PIN_W-1:0]  pin_q, pin_d;
   logic [AMT_W-1:0]  amt_q, amt_d;

   logic [AMT_W-1:0]     bal_q [NUM_ACCTS];
   logic [AMT_W-1:0]     bal_d [NUM_ACCTS];
   logic [2:0]           fail_q [NUM_ACCTS];
   logic [2:0]           fail_d [NUM_ACCTS];
   logic [NUM_ACCTS-1:0] lock_q, lock_d;
   logic                 auth_vld_q, auth_vld_d;
   logic [ACCT_W-1:0]    auth_acct_q, auth_acct_d;

   logic              rsp_pin_correct_q, rsp_pin_correct_d;
   logic              rsp_balance_ok_q, rsp_balance_ok_d;
   logic              rsp_locked_q, rsp_locked_d;
   logic [AMT_W-1:0]  rsp_balance_q, rsp_balance_d;

   logic [AMT_W-1:0]  cur_bal;
   logic [2:0]        cur_fail;
   logic [2:0]        fail_nxt;
   logic              cur_lock;
   logic              pin_match;
   logic              authed;
   logic              approved;

   // PINs are never rewritten, so the table entry is just the reset formula.
   assign cur_bal   = bal_q[acct_q];
   assign cur_fail  = fail_q[acct_q];
   assign cur_lock  = lock_q[acct_q];
   assign fail_nxt  = (cur_fail >= 3'(MAX_TRIES)) ? cur_fail : cur_fail + 3'd1;
   assign pin_match = (pin_q == DEFAULT_PIN + PIN_W'(acct_q));
   assign authed    = auth_vld_q && (auth_acct_q == acct_q) && !cur_lock;
   assign approved  = authed && (amt_q != '0) && (amt_q <= cur_bal);

   always_comb begin
      state_d           = state_q;
      cnt_d             = cnt_q;
      op_d              = op_q;
      acct_d            = acct_q;
      pin_d             = pin_q;
      amt_d             = amt_q;
      bal_d             = bal_q;
      fail_d            = fail_q;
      lock_d            = lock_q;
      auth_vld_d        = auth_vld_q;
      auth_acct_d       = auth_acct_q;
      rsp_pin_correct_d = rsp_pin_correct_q;
      rsp_balance_ok_d  = rsp_balance_ok_q;
      rsp_locked_d      = rsp_locked_q;
      rsp_balance_d     = rsp_balance_q;

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               op_d    = req_op;
               acct_d  = req_acct;
               pin_d   = req_pin;
               amt_d   = req_amount;
               cnt_d   = '0;
               state_d = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            if (cnt_q == 3'(LATENCY - 1)) begin
               state_d    = S_RESPOND;
               auth_vld_d = 1'b0;
               if (!op_q) begin
                  rsp_balance_ok_d = 1'b0;
                  rsp_balance_d    = cur_bal;
                  if (cur_lock) begin
                     rsp_pin_correct_d = 1'b0;
                     rsp_locked_d      = 1'b1;
                  end else if (pin_match) begin
                     rsp_pin_correct_d = 1'b1;
                     rsp_locked_d      = 1'b0;
                     fail_d[acct_q]    = '0;
                     auth_vld_d        = 1'b1;
                     auth_acct_d       = acct_q;
                  end else begin
                     rsp_pin_correct_d = 1'b0;
                     fail_d[acct_q]    = fail_nxt;
                     lock_d[acct_q]    = (fail_nxt == 3'(MAX_TRIES));
                     rsp_locked_d      = (fail_nxt == 3'(MAX_TRIES));
                  end
               end else begin
                  rsp_pin_correct_d = authed;
                  rsp_balance_ok_d  = approved;
                  rsp_locked_d      = cur_lock;
                  rsp_balance_d     = approved ? cur_bal - amt_q : cur_bal;
                  bal_d[acct_q]     = approved ? cur_bal - amt_q : cur_bal;
               end
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         S_RESPOND: begin
            if (rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q           <= S_IDLE;
         cnt_q             <= '0;
         op_q              <= 1'b0;
         acct_q            <= '0;
         pin_q             <= '0;
         amt_q             <= '0;
         for (int i = 0; i < NUM_ACCTS; i++) begin
            bal_q[i]  <= AMT_W'(INIT_BALANCE);
            fail_q[i] <= '0;
         end
         lock_q            <= '0;
         auth_vld_q        <= 1'b0;
         auth_acct_q       <= '0;
         rsp_pin_correct_q <= 1'b0;
         rsp_balance_ok_q  <= 1'b0;
         rsp_locked_q      <= 1'b0;
         rsp_balance_q     <= '0;
      end else begin
         state_q           <= state_d;
         cnt_q             <= cnt_d;
         op_q              <= op_d;
         acct_q            <= acct_d;
         pin_q             <= pin_d;
         amt_q             <= amt_d;
         bal_q             <= bal_d;
         fail_q            <= fail_d;
         lock_q            <= lock_d;
         auth_vld_q        <= auth_vld_d;
         auth_acct_q       <= auth_acct_d;
         rsp_pin_correct_q <= rsp_pin_correct_d;
         rsp_balance_ok_q  <= rsp_balance_ok_d;
         rsp_locked_q      <= rsp_locked_d;
         rsp_balance_q     <= rsp_balance_d;
      end
   end

   assign req_ready       = (state_q == S_IDLE);
   assign rsp_valid       = (state_q == S_RESPOND);
   assign rsp_pin_correct = rsp_pin_correct_q;
   assign rsp_balance_ok  = rsp_balance_ok_q;
   assign rsp_locked      = rsp_locked_q;
   assign rsp_balance     = rsp_balance_q;

endmodule

// File: tb/tb_atm_bank_responder.sv
// Scoreboarded bench for atm_bank_responder: directed scenarios then random traffic
// against an account-level reference model.
module tb_atm_bank_responder;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_op = 1'b0;
   logic [1:0]  req_acct = '0;
   logic [15:0] req_pin = '0;
   logic [15:0] req_amount = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic        rsp_pin_correct;
   logic        rsp_balance_ok;
   logic        rsp_locked;
   logic [15:0] rsp_balance;

   atm_bank_responder #(.LATENCY(LAT)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_acct(req_acct), .req_pin(req_pin), .req_amount(req_amount),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_pin_correct(rsp_pin_correct), .rsp_balance_ok(rsp_balance_ok),
      .rsp_locked(rsp_locked), .rsp_balance(rsp_balance)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        pc;
      logic        bo;
      logic        lk;
      logic [15:0] bal;
   } exp_t;

   exp_t exp_q[$];
   int   lat_q[$];
   int   vecs = 0;
   int   errs = 0;
   int   cyc = 0;
   int   stall_left = 0;

   // Reference model: per-account state as plain integers.
   int m_bal [4];
   int m_fail[4];
   bit m_lock[4];
   bit m_auth_v;
   int m_auth_a;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      vecs++;
      if (act !== expv) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_bal[i] = 1000; m_fail[i] = 0; m_lock[i] = 0;
      end
      m_auth_v = 0;
      m_auth_a = 0;
   endtask

   task automatic model(input logic op, input int a, input logic [15:0] pin,
                        input int amt, output exp_t e);
      logic [15:0] good;
      bit auth;
      good = 16'h1234 + 16'(a);
      e.bo = 0;
      if (!op) begin
         if (m_lock[a]) begin
            e.pc = 0; e.lk = 1;
            m_auth_v = 0;
         end else if (pin == good) begin
            e.pc = 1; e.lk = 0;
            m_fail[a] = 0; m_auth_v = 1; m_auth_a = a;
         end else begin
            e.pc = 0;
            if (m_fail[a] < 3) m_fail[a]++;
            if (m_fail[a] == 3) m_lock[a] = 1;
            e.lk = m_lock[a];
            m_auth_v = 0;
         end
      end else begin
         auth = m_auth_v && (m_auth_a == a) && !m_lock[a];
         e.pc = auth;
         if (auth && amt > 0 && amt <= m_bal[a]) begin
            e.bo = 1;
            m_bal[a] -= amt;
         end
         e.lk = m_lock[a];
         m_auth_v = 0;
      end
      e.bal = 16'(m_bal[a]);
   endtask

   // Response ready: random, or held low for a number of valid cycles.
   always @(posedge clk) begin
      #1;
      if (stall_left > 0) begin
         rsp_ready = 1'b0;
         if (rsp_valid) stall_left--;
      end else begin
         rsp_ready = ($urandom % 4) != 0;
      end
   end

   // Monitor: sampled on the falling edge, pops the scoreboard on each handshake.
   logic        prev_v = 0, prev_hs = 0;
   logic [18:0] prev_f = '0;
   always @(negedge clk) begin
      exp_t e;
      int   acc;
      logic [18:0] f;
      f = {rsp_pin_correct, rsp_balance_ok, rsp_locked, rsp_balance};
      if (!rst) begin
         prev_v = 0; prev_hs = 0;
      end else begin
         if (prev_hs) begin
            chk("ready_after_rsp", {31'b0, req_ready}, 32'd1);
            chk("valid_drop", {31'b0, rsp_valid}, 32'd0);
            chk("rsp_retained", {13'b0, f}, {13'b0, prev_f});
         end
         if (rsp_valid) begin
            chk("req_ready_busy", {31'b0, req_ready}, 32'd0);
            if (!prev_v) begin
               if (lat_q.size() == 0) begin
                  chk("unexpected_rsp", 32'd1, 32'd0);
               end else begin
                  acc = lat_q.pop_front();
                  chk("latency", cyc - acc, LAT);
               end
            end else if (!prev_hs) begin
               chk("rsp_stable", {13'b0, f}, {13'b0, prev_f});
            end
            if (rsp_ready) begin
               if (exp_q.size() == 0) begin
                  chk("scoreboard_empty", 32'd1, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  chk("rsp_fields", {13'b0, f}, {13'b0, e.pc, e.bo, e.lk, e.bal});
               end
            end
         end
         prev_v  = rsp_valid;
         prev_hs = rsp_valid && rsp_ready;
         prev_f  = f;
      end
   end

   // Called at posedge+1; returns at posedge+1 right after acceptance.
   task automatic issue(input logic op, input int a, input logic [15:0] pin,
                        input int amt, input bit commit);
      bit   acc = 0;
      int   n = 0;
      exp_t e;
      req_valid = 1; req_op = op; req_acct = a[1:0]; req_pin = pin; req_amount = amt[15:0];
      while (!acc && n < 100) begin
         @(negedge clk);
         acc = req_ready;
         @(posedge clk);
         #1;
         n++;
      end
      req_valid = 0;
      if (!acc) begin
         chk("accept_timeout", 32'd0, 32'd1);
      end else if (commit) begin
         model(op, a, pin, amt, e);
         exp_q.push_back(e);
         lat_q.push_back(cyc);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((exp_q.size() != 0 || rsp_valid) && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 200) chk("drain_timeout", 32'd0, 32'd1);
   endtask

   task automatic reset_dut();
      rst = 0; req_valid = 0; stall_left = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
      chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("rst_rsp_fields",
          {13'b0, rsp_pin_correct, rsp_balance_ok, rsp_locked, rsp_balance}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1;
      model_reset();
      exp_q.delete();
      lat_q.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs + 1);
      $fatal(1);
   end

   initial begin
      @(posedge clk);
      #1;
      reset_dut();

      issue(0, 0, 16'h1234, 0, 1);
      issue(1, 0, 16'h0000, 300, 1);
      issue(1, 0, 16'h0000, 100, 1);
      repeat (3) issue(0, 1, 16'h0000, 0, 1);
      issue(0, 1, 16'h1235, 0, 1);
      issue(0, 2, 16'h1236, 0, 1);
      issue(1, 2, 16'h0000, 1001, 1);
      issue(0, 2, 16'h1236, 0, 1);
      issue(1, 2, 16'h0000, 1000, 1);
      issue(0, 2, 16'h1236, 0, 1);
      issue(1, 2, 16'h0000, 0, 1);
      wait_idle();

      // Stall the response; the following request stays asserted and must be ignored.
      stall_left = 6;
      issue(0, 0, 16'h1234, 0, 1);
      issue(1, 0, 16'h0000, 50, 1);
      wait_idle();

      // Reset during the lookup of a withdrawal: no debit may survive.
      issue(0, 3, 16'h1237, 0, 1);
      wait_idle();
      issue(1, 3, 16'h0000, 500, 0);
      reset_dut();
      issue(0, 3, 16'h1237, 0, 1);
      wait_idle();

      for (int r = 0; r < 2; r++) begin
         reset_dut();
         for (int k = 0; k < 150; k++) begin
            int          a;
            logic [15:0] p;
            a = $urandom % 4;
            p = (($urandom % 4) != 0) ? 16'(16'h1234 + 16'(a)) : 16'($urandom);
            issue(1'($urandom % 2), a, p, $urandom_range(0, 1100), 1);
         end
         wait_idle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
